// File: rtl/lz_pkg.sv
// Shared leading-zero index definitions for the encoder and expander sides.
// Both sides must agree that count == LZ_W means "no bit set".
package lz_pkg;

    localparam int unsigned LZ_W  = 32;
    localparam int unsigned LZ_CW = $clog2(LZ_W) + 1;

    typedef enum logic {
        LZX_ACC,
        LZX_HOLD
    } lzx_state_e;

    // Count n selects bit (LZ_W-1-n); counts at or beyond LZ_W yield an empty mask.
    function automatic logic [LZ_W-1:0] lz_onehot(input logic [LZ_CW-1:0] count);
        logic [LZ_W-1:0] mask;
        mask = '0;
        if (count < LZ_CW'(LZ_W)) begin
            mask = {{(LZ_W-1){1'b0}}, 1'b1} << (LZ_CW'(LZ_W - 1) - count);
        end
        return mask;
    endfunction

endpackage

// File: rtl/lz_bitmap_expander_if.sv
// Token input stream and assembled-word output stream of the bitmap expander.
interface lz_bitmap_expander_if
    import lz_pkg::*;
#(
    parameter int unsigned W = LZ_W
);
    localparam int unsigned CW = $clog2(W) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_count;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_bitmap;
    logic [CW-1:0] out_ntok;
    logic          out_dup;
    logic          out_range;

    modport master (
        output in_valid, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_bitmap, out_ntok, out_dup, out_range
    );

    modport slave (
        input  in_valid, in_count, in_last, out_ready,
        output in_ready, out_valid, out_bitmap, out_ntok, out_dup, out_range
    );

endinterface

// File: rtl/lz_bitmap_expander_decode.sv
// Combinational decode of one leading-zero count into a one-hot mask plus range flag.
module lz_decode #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = $clog2(W) + 1
) (
    input  logic [CW-1:0] count_i,
    output logic [W-1:0]  onehot_o,
    output logic          range_o
);

    always_comb begin
        onehot_o = '0;
        range_o  = 1'b0;
        if (count_i < CW'(W)) begin
            onehot_o = {{(W-1){1'b0}}, 1'b1} << (CW'(W - 1) - count_i);
        end else if (count_i > CW'(W)) begin
            range_o = 1'b1;
        end
    end

endmodule

// File: rtl/lz_bitmap_expander.sv
// Rebuilds a W-bit occupancy bitmap by OR-accumulating leading-zero count tokens;
// the word is released on the token flagged last.
module lz_bitmap_expander
    import lz_pkg::*;
#(
    parameter int unsigned W = LZ_W
) (
    input  logic                 clk,
    input  logic                 nreset,
    lz_bitmap_expander_if.slave  bus
);

    localparam int unsigned CW = $clog2(W) + 1;

    lzx_state_e    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] ntok_q, ntok_d;
    logic          dup_q, dup_d;
    logic          rng_q, rng_d;
    logic [W-1:0]  obm_q, obm_d;
    logic [CW-1:0] ontok_q, ontok_d;
    logic          odup_q, odup_d;
    logic          orng_q, orng_d;

    logic          in_ready;
    logic          accept;
    logic [W-1:0]  onehot;
    logic          rng_tok;
    logic [W-1:0]  acc_upd;
    logic [CW-1:0] ntok_upd;
    logic          dup_upd;
    logic          rng_upd;

    lz_decode #(.W(W), .CW(CW)) u_decode (
        .count_i  (bus.in_count),
        .onehot_o (onehot),
        .range_o  (rng_tok)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= LZX_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LZX_ACC:  if (accept && bus.in_last) state_d = LZX_HOLD;
            LZX_HOLD: if (bus.out_ready) state_d = (accept && bus.in_last) ? LZX_HOLD : LZX_ACC;
            default:  state_d = LZX_ACC;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == LZX_ACC) || bus.out_ready;
        bus.out_valid = (state_q == LZX_HOLD);
    end

    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;

    // The accumulator is cleared when a word is released, so a token arriving
    // during the HOLD handshake cycle lands in an empty word.
    assign acc_upd  = acc_q | onehot;
    assign dup_upd  = dup_q | (|(acc_q & onehot));
    assign rng_upd  = rng_q | rng_tok;
    assign ntok_upd = (ntok_q == '1) ? ntok_q : ntok_q + 1'b1;

    always_comb begin
        acc_d   = acc_q;
        ntok_d  = ntok_q;
        dup_d   = dup_q;
        rng_d   = rng_q;
        obm_d   = obm_q;
        ontok_d = ontok_q;
        odup_d  = odup_q;
        orng_d  = orng_q;
        if (accept) begin
            if (bus.in_last) begin
                obm_d   = acc_upd;
                ontok_d = ntok_upd;
                odup_d  = dup_upd;
                orng_d  = rng_upd;
                acc_d   = '0;
                ntok_d  = '0;
                dup_d   = 1'b0;
                rng_d   = 1'b0;
            end else begin
                acc_d   = acc_upd;
                ntok_d  = ntok_upd;
                dup_d   = dup_upd;
                rng_d   = rng_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc_q   <= '0;
            ntok_q  <= '0;
            dup_q   <= 1'b0;
            rng_q   <= 1'b0;
            obm_q   <= '0;
            ontok_q <= '0;
            odup_q  <= 1'b0;
            orng_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ntok_q  <= ntok_d;
            dup_q   <= dup_d;
            rng_q   <= rng_d;
            obm_q   <= obm_d;
            ontok_q <= ontok_d;
            odup_q  <= odup_d;
            orng_q  <= orng_d;
        end
    end

    assign bus.out_bitmap = obm_q;
    assign bus.out_ntok   = ontok_q;
    assign bus.out_dup    = odup_q;
    assign bus.out_range  = orng_q;

endmodule

// File: tb/tb_lz_bitmap_expander.sv
// Bench for lz_bitmap_expander: vector table, handshake corner sequences, and
// randomized traffic against a word-level reference model.
module tb_lz_bitmap_expander;
    import lz_pkg::*;

    localparam int W = LZ_W;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    lz_bitmap_expander_if #(.W(W)) bus ();

    lz_bitmap_expander #(.W(W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          n;
        int          t0, t1, t2, t3;
        logic [31:0] bm;
        int          ntok;
        bit          dup;
        bit          rng;
    } vec_t;

    typedef struct {
        logic [31:0] bm;
        int          ntok;
        bit          dup;
        bit          rng;
    } exp_t;

    vec_t vecs[6];
    exp_t expq[$];

    logic [31:0] m_bm;
    int          m_ntok;
    bit          m_dup;
    bit          m_rng;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Hold a token until it is accepted, bounded by a cycle budget.
    task automatic send(input int c, input bit last);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_count = LZ_CW'(c);
        bus.in_last  = last;
        for (int k = 0; k < 50 && !done; k++) begin
            #1;
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #2;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: token %0d never accepted", c);
        end
    endtask

    task automatic model_clear();
        m_bm   = '0;
        m_ntok = 0;
        m_dup  = 1'b0;
        m_rng  = 1'b0;
    endtask

    task automatic model_token(input int n, input bit last);
        logic [31:0] mask;
        exp_t e;
        if (n < W) begin
            mask = 32'h8000_0000 >> n;
            if ((m_bm & mask) != 0) m_dup = 1'b1;
            m_bm = m_bm | mask;
        end else if (n > W) begin
            m_rng = 1'b1;
        end
        m_ntok = (m_ntok < 63) ? m_ntok + 1 : 63;
        if (last) begin
            e.bm = m_bm; e.ntok = m_ntok; e.dup = m_dup; e.rng = m_rng;
            expq.push_back(e);
            model_clear();
        end
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] expbm;
        exp_t        e;
        int          toks[4];
        int          budget;

        vecs[0] = '{3, 0, 31, 5, 0,   32'h8400_0001, 3, 1'b0, 1'b0};
        vecs[1] = '{2, 32, 32, 0, 0,  32'h0000_0000, 2, 1'b0, 1'b0};
        vecs[2] = '{2, 7, 7, 0, 0,    32'h0100_0000, 2, 1'b1, 1'b0};
        vecs[3] = '{1, 40, 0, 0, 0,   32'h0000_0000, 1, 1'b0, 1'b1};
        vecs[4] = '{1, 0, 0, 0, 0,    32'h8000_0000, 1, 1'b0, 1'b0};
        vecs[5] = '{4, 32, 33, 16, 16, 32'h0000_8000, 4, 1'b1, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_count  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_bitmap",    64'(bus.out_bitmap), 64'd0);
        chk("rst_ntok",      64'(bus.out_ntok), 64'd0);
        chk("rst_flags",     64'({bus.out_dup, bus.out_range}), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        nreset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            toks = '{vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3};
            for (int k = 0; k < vecs[i].n; k++) send(toks[k], k == vecs[i].n - 1);
            chk($sformatf("vec%0d_valid", i),  64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_bitmap", i), 64'(bus.out_bitmap), 64'(vecs[i].bm));
            chk($sformatf("vec%0d_ntok", i),   64'(bus.out_ntok), 64'(vecs[i].ntok));
            chk($sformatf("vec%0d_dup", i),    64'(bus.out_dup), 64'(vecs[i].dup));
            chk($sformatf("vec%0d_range", i),  64'(bus.out_range), 64'(vecs[i].rng));
            step();
            chk($sformatf("vec%0d_drained", i), 64'(bus.out_valid), 64'd0);
        end

        // Token counter saturates at 63.
        for (int k = 0; k < 69; k++) send(32, 1'b0);
        send(32, 1'b1);
        chk("sat_ntok",   64'(bus.out_ntok), 64'd63);
        chk("sat_bitmap", 64'(bus.out_bitmap), 64'd0);
        step();

        // Backpressure: word held while downstream stalls.
        bus.out_ready = 1'b0;
        send(2, 1'b1);
        held = 32'h2000_0000;
        bus.in_valid = 1'b1;
        bus.in_count = LZ_CW'(9);
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            chk("hold_valid",    64'(bus.out_valid), 64'd1);
            chk("hold_bitmap",   64'(bus.out_bitmap), 64'(held));
            chk("hold_ntok",     64'(bus.out_ntok), 64'd1);
            step();
        end
        bus.out_ready = 1'b1;
        bus.in_count  = LZ_CW'(1);
        #1;
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("b2b_valid",  64'(bus.out_valid), 64'd1);
        chk("b2b_bitmap", 64'(bus.out_bitmap), 64'h4000_0000);
        chk("b2b_ntok",   64'(bus.out_ntok), 64'd1);
        step();
        chk("b2b_drained", 64'(bus.out_valid), 64'd0);

        // One single-bit word per cycle with no bubble.
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.in_count = LZ_CW'(i);
            bus.in_last  = 1'b1;
            step();
            expbm = 32'h8000_0000 >> i;
            chk($sformatf("stream%0d_valid", i),  64'(bus.out_valid), 64'd1);
            chk($sformatf("stream%0d_bitmap", i), 64'(bus.out_bitmap), 64'(expbm));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();

        // Reset mid-word drops the partial accumulation.
        send(3, 1'b0);
        send(4, 1'b0);
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_ntok",  64'(bus.out_ntok), 64'd0);
        send(9, 1'b1);
        chk("midrst_bitmap", 64'(bus.out_bitmap), 64'h0040_0000);
        chk("midrst_ntok1",  64'(bus.out_ntok), 64'd1);
        step();

        // Randomized traffic against the word-level model.
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.in_count  = LZ_CW'($urandom_range(0, 45));
            bus.in_last   = ($urandom_range(0, 3) == 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL rand_unexpected_word: got bitmap %0h expected no word", bus.out_bitmap);
                end else begin
                    e = expq.pop_front();
                    chk("rand_bitmap", 64'(bus.out_bitmap), 64'(e.bm));
                    chk("rand_ntok",   64'(bus.out_ntok), 64'(e.ntok));
                    chk("rand_dup",    64'(bus.out_dup), 64'(e.dup));
                    chk("rand_range",  64'(bus.out_range), 64'(e.rng));
                end
            end
            if (bus.in_valid && bus.in_ready) model_token(int'(bus.in_count), bus.in_last);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        budget = 0;
        while (expq.size() != 0 && budget < 20) begin
            #1;
            if (bus.out_valid) begin
                e = expq.pop_front();
                chk("drain_bitmap", 64'(bus.out_bitmap), 64'(e.bm));
                chk("drain_ntok",   64'(bus.out_ntok), 64'(e.ntok));
            end
            step();
            budget++;
        end
        chk("rand_queue_empty", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
